// File: rtl/rom_seq_reader_pkg.sv
// Shared constants and state encoding for the sequential ROM reader.
package rom_seq_reader_pkg;

    localparam int unsigned ROM_ADDR_W = 2;
    localparam int unsigned ROM_DATA_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        SEND  = ST_SEND,
        DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/rom_seq_reader.sv
// Scans an asynchronous ROM from address 0 to N-1 and presents each word on a
// valid/ready stream while accumulating an XOR checksum of the accepted words.
module rom_seq_reader
    import rom_seq_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int unsigned        N         = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state and output-register logic; busy/done are registered copies
    // of the next state so they line up with the state they describe.
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        checksum_d  = checksum_q;
        out_valid_d = out_valid_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    checksum_d = '0;
                    rom_addr_d = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                // ROM has had the whole cycle to settle on rom_addr_q.
                out_data_d  = rom_data;
                out_addr_d  = rom_addr_q;
                checksum_d  = checksum_q ^ rom_data;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (rom_addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        state_d    = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            checksum_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            checksum_q  <= checksum_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_rom_seq_reader.sv
// Directed bench for rom_seq_reader paired with a behavioural 4x4 async ROM.
module tb_rom_seq_reader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] rom_addr;
    logic [3:0] rom_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_addr;
    logic       busy;
    logic       done;
    logic [3:0] checksum;

    int n_tests;
    int n_fail;

    rom_seq_reader #(.ADDR_W(2), .DATA_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_addr (out_addr),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    // Behavioural ROM contents {0:A, 1:5, 2:3, 3:E}
    always_comb begin
        case (rom_addr)
            2'd0:    rom_data = 4'hA;
            2'd1:    rom_data = 4'h5;
            2'd2:    rom_data = 4'h3;
            default: rom_data = 4'hE;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       start;
        logic       ready;
        logic       valid;
        logic [3:0] data;
        logic [1:0] addr;
        logic [1:0] raddr;
        logic       busy;
        logic       done;
        logic [3:0] cs;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int st, input int rd, input int vl, input int dt,
                                input int ad, input int ra, input int bs, input int dn,
                                input int cs);
        vec_t v;
        v.start = 1'(st);
        v.ready = 1'(rd);
        v.valid = 1'(vl);
        v.data  = 4'(dt);
        v.addr  = 2'(ad);
        v.raddr = 2'(ra);
        v.busy  = 1'(bs);
        v.done  = 1'(dn);
        v.cs    = 4'(cs);
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"},    int'(out_valid), 0);
        check({tag, ".data"},     int'(out_data),  0);
        check({tag, ".addr"},     int'(out_addr),  0);
        check({tag, ".rom_addr"}, int'(rom_addr),  0);
        check({tag, ".busy"},     int'(busy),      0);
        check({tag, ".done"},     int'(done),      0);
        check({tag, ".checksum"}, int'(checksum),  0);
    endtask

    initial begin
        int         found;
        int         nwords;
        int         ndone;
        logic [3:0] exp_words [4];
        logic [3:0] got_data  [4];
        logic [1:0] got_addr  [4];

        n_tests = 0;
        n_fail  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        exp_words[0] = 4'hA;
        exp_words[1] = 4'h5;
        exp_words[2] = 4'h3;
        exp_words[3] = 4'hE;

        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        // Each row: inputs for one cycle, then outputs seen after the edge.
        //  start ready | valid data addr raddr busy done cs
        // Scan 1, out_ready tied high.
        add(1, 1, 0, 'h0, 0, 0, 1, 0, 'h0);
        add(0, 1, 1, 'hA, 0, 0, 1, 0, 'hA);
        add(0, 1, 0, 'hA, 0, 1, 1, 0, 'hA);
        add(0, 1, 1, 'h5, 1, 1, 1, 0, 'hF);
        add(0, 1, 0, 'h5, 1, 2, 1, 0, 'hF);
        add(0, 1, 1, 'h3, 2, 2, 1, 0, 'hC);
        add(0, 1, 0, 'h3, 2, 3, 1, 0, 'hC);
        add(0, 1, 1, 'hE, 3, 3, 1, 0, 'h2);
        add(0, 1, 0, 'hE, 3, 3, 1, 1, 'h2);
        add(0, 1, 0, 'hE, 3, 3, 0, 0, 'h2);
        // Back-to-back start in cycle 10; 3-cycle stall on addr 1; stray start mid-scan.
        add(1, 1, 0, 'hE, 3, 0, 1, 0, 'h0);
        add(0, 0, 1, 'hA, 0, 0, 1, 0, 'hA);
        add(0, 1, 0, 'hA, 0, 1, 1, 0, 'hA);
        add(0, 0, 1, 'h5, 1, 1, 1, 0, 'hF);
        add(0, 0, 1, 'h5, 1, 1, 1, 0, 'hF);
        add(1, 0, 1, 'h5, 1, 1, 1, 0, 'hF);
        add(0, 0, 1, 'h5, 1, 1, 1, 0, 'hF);
        add(0, 1, 0, 'h5, 1, 2, 1, 0, 'hF);
        add(1, 1, 1, 'h3, 2, 2, 1, 0, 'hC);
        add(0, 1, 0, 'h3, 2, 3, 1, 0, 'hC);
        add(0, 1, 1, 'hE, 3, 3, 1, 0, 'h2);
        add(0, 1, 0, 'hE, 3, 3, 1, 1, 'h2);
        add(0, 1, 0, 'hE, 3, 3, 0, 0, 'h2);
        // Idle with out_ready high: nothing emitted.
        add(0, 1, 0, 'hE, 3, 3, 0, 0, 'h2);
        add(0, 1, 0, 'hE, 3, 3, 0, 0, 'h2);

        for (int i = 0; i < tbl.size(); i++) begin
            start     = tbl[i].start;
            out_ready = tbl[i].ready;
            step();
            check($sformatf("vec%0d.valid", i),    int'(out_valid), int'(tbl[i].valid));
            check($sformatf("vec%0d.data", i),     int'(out_data),  int'(tbl[i].data));
            check($sformatf("vec%0d.addr", i),     int'(out_addr),  int'(tbl[i].addr));
            check($sformatf("vec%0d.rom_addr", i), int'(rom_addr),  int'(tbl[i].raddr));
            check($sformatf("vec%0d.busy", i),     int'(busy),      int'(tbl[i].busy));
            check($sformatf("vec%0d.done", i),     int'(done),      int'(tbl[i].done));
            check($sformatf("vec%0d.checksum", i), int'(checksum),  int'(tbl[i].cs));
        end

        // Reset while the word at addr 2 is pending in SEND.
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (out_valid && out_addr == 2'd2) begin
                found = 1;
                break;
            end
        end
        check("midsend.reached_addr2", found, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("midsend_rst");
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (done) ndone++;
        end
        check("midsend.no_done", ndone, 0);
        check("midsend.idle_busy", int'(busy), 0);

        // Full scan after the aborted one.
        start = 1'b1;
        step();
        start  = 1'b0;
        nwords = 0;
        ndone  = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (out_valid) begin
                if (nwords < 4) begin
                    got_data[nwords] = out_data;
                    got_addr[nwords] = out_addr;
                end
                nwords++;
            end
            if (done) begin
                ndone++;
                break;
            end
        end
        check("rescan.words", nwords, 4);
        check("rescan.done_pulses", ndone, 1);
        for (int k = 0; k < 4; k++) begin
            if (k < nwords) begin
                check($sformatf("rescan.data%0d", k), int'(got_data[k]), int'(exp_words[k]));
                check($sformatf("rescan.addr%0d", k), int'(got_addr[k]), k);
            end
        end
        check("rescan.checksum", int'(checksum), 2);
        step();
        check("rescan.idle", int'(busy), 0);
        check("rescan.done_cleared", int'(done), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_seq_reader.md
# rom_seq_reader

Sequential reader for the team's 4x4 asynchronous ROM: on a start pulse it drives ROM addresses 0 through 2**ADDR_W-1 in order. Each word is captured in a register and presented on a valid/ready output stream, and a running XOR checksum is accumulated. It is the consumer of the ROM's combinational read port: the ROM responds, this block initiates and sequences. Downstream logic takes the ROM contents as a flow-controlled word stream instead of sampling the ROM directly.

## Interface
Parameters:
- ADDR_W, 2, ROM address width; word count N = 2**ADDR_W
- DATA_W, 4, ROM data width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin one full scan; sampled only in IDLE
- rom_addr  output  ADDR_W  address to ROM (registered)
- rom_data  input  DATA_W  combinational ROM read data
- out_valid  output  1  out_data/out_addr hold a valid word
- out_ready  input  1  downstream accepts the word
- out_data  output  DATA_W  captured ROM word
- out_addr  output  ADDR_W  address of out_data
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last word is accepted
- checksum  output  DATA_W  XOR of all words accepted in the current or last scan

## Operation
- Reset: state IDLE. rom_addr, out_data, out_addr and checksum are 0. out_valid, busy and done are 0.
- IDLE: when start=1, clear checksum, set rom_addr=0 and go to FETCH. When start=0, stay in IDLE and hold checksum.
- FETCH: lasts exactly one cycle and gives the ROM a full cycle to settle. At the closing edge:
  - out_data <= rom_data
  - out_addr <= rom_addr
  - checksum <= checksum ^ rom_data
  - out_valid <= 1
  - go to SEND
- SEND: out_valid=1. out_data and out_addr stay stable until the handshake completes (out_valid & out_ready at a rising edge). On handshake:
  - out_valid <= 0
  - if rom_addr == N-1, go to DONE
  - otherwise rom_addr <= rom_addr+1 and go to FETCH
- DONE: done=1 for exactly one cycle, then go to IDLE. checksum holds its value until the next start.
- start while busy=1 is ignored and has no effect on the scan in progress.
- out_ready outside SEND is ignored.
- Address arithmetic is unsigned, ADDR_W bits. The last-word test is an equality compare with N-1, so the address never wraps within a scan.
- rst=1 in any state, including mid-SEND, forces the reset values at the next edge. The pending word is dropped and done does not pulse.

## Timing
- start sampled high at edge 0:
  - FETCH in cycle 1
  - first out_valid visible in cycle 2
- Minimum of 2 cycles per word, FETCH plus a single-cycle SEND.
- With out_ready tied to 1 and N=4:
  - out_valid high in cycles 2, 4, 6 and 8
  - done high in cycle 9
  - IDLE with busy=0 in cycle 10
- A back-to-back start in cycle 10 is accepted.
- Stall: each cycle out_ready is low in SEND adds one cycle. Outputs are unchanged during a stall.
- checksum updates at the FETCH closing edge, so it includes the current out_data while that word is still in SEND.
- There is no combinational path from any input to any output. rom_addr is registered.

## Structure
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, FETCH=2'd1, SEND=2'd2, DONE=2'd3
  - default ADDR_W/DATA_W constants shared with the ROM
- Single module: a state register, an address counter and output registers. No sub-module.
- The bench pairs this block with a behavioural 4x4 asynchronous ROM model with contents {0:A, 1:5, 2:3, 3:E}.

## Test plan
- Reset, then start pulse with out_ready=1 -> (addr, data) stream (0,A), (1,5), (2,3), (3,E) in cycles 2/4/6/8; done in cycle 9; checksum=2.
- out_ready low for 3 cycles during the word at addr 1 -> out_data=5 and out_addr=1 held stable throughout the stall; done in cycle 12; checksum=2.
- start pulsed again in cycle 5 of a scan -> ignored: exactly 4 words emitted and one done pulse.
- rst asserted while in SEND with addr 2 -> next cycle all outputs 0, state IDLE, no done pulse; a later start gives a full scan with checksum=2.
- Two back-to-back scans, second start in cycle 10 -> checksum cleared and recomputed to 2; second stream starts at addr 0.
- out_ready held high while idle -> out_valid stays 0 and nothing is emitted.
